// File: rtl/sam_modexp_decoder.sv
// ============================================================================
//  Module   : sam_modexp_decoder
//  Purpose  : Serial-configured modular exponentiation decoder. Loads a key
//             length code n, exponent d and modulus N, then decrypts framed
//             ciphertexts as M = C^d mod N using constant-time
//             square-and-multiply built on an interleaved modular multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sam_modexp_decoder #(
    parameter int MAX_KEY = 16,
    parameter int NW      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mode,
    input  logic str,
    output logic msg,
    output logic frame,
    output logic cfg_done,
    output logic cfg_err,
    output logic busy
);

    localparam int W  = MAX_KEY + 1;              // multiplier datapath width
    localparam int IW = $clog2(MAX_KEY);          // bit-index width
    localparam int KW = IW + 1;                   // width able to hold MAX_KEY
    localparam int CW = $clog2(NW + 2 * MAX_KEY + 1);
    localparam logic [CW-1:0] C_NW = CW'(NW);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_WAIT_START, S_RX, S_REDUCE, S_EXP_SQ, S_EXP_MUL, S_TX
    } state_t;

    state_t                state_q;
    logic [NW-1:0]         n_q;
    logic [MAX_KEY-1:0]    d_q, mod_q, c_q, cr_q, x_q, a_q, b_q;
    logic [W-1:0]          r_q;
    logic [IW-1:0]         k_q, e_q;
    logic [CW-1:0]         cnt_q;
    logic                  tx_end_q;
    logic                  msg_q, frame_q, cfg_done_q, cfg_err_q, busy_q;

    // One interleaved step: R = 2R mod N, then conditionally R = R + B mod N.
    // Operands are always below N (B may equal N only when N = 1), so a single
    // conditional subtraction after each addition suffices.
    function automatic logic [W-1:0] mm_step(input logic [W-1:0] r,
                                             input logic         a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W-1:0] t;
        t = r << 1;
        if (t >= m) t = t - m;
        if (a) begin
            t = t + b;
            if (t >= m) t = t - m;
        end
        return t;
    endfunction

    logic [KW-1:0]      w_len;
    logic [IW-1:0]      w_len_m1;
    logic [CW-1:0]      w_len_c, w_d_end, w_n_end;
    logic               w_key_ok, w_cfg_valid;
    logic [W-1:0]       r_d;
    logic [MAX_KEY-1:0] res_d, x_mul_d, x_init_d, c_d;

    assign w_len       = KW'(1) << n_q;
    assign w_len_m1    = IW'(w_len - KW'(1));
    assign w_len_c     = CW'(w_len);
    assign w_d_end     = C_NW + w_len_c;
    assign w_n_end     = w_d_end + w_len_c;
    assign w_key_ok    = (32'(n_q) <= IW);
    assign w_cfg_valid = w_key_ok && (cnt_q == w_n_end) && (mod_q != '0);

    assign r_d      = mm_step(r_q, a_q[k_q], {1'b0, b_q}, {1'b0, mod_q});
    assign res_d    = r_d[MAX_KEY-1:0];
    assign x_mul_d  = d_q[e_q] ? res_d : x_q;
    assign x_init_d = (mod_q == MAX_KEY'(1)) ? '0 : MAX_KEY'(1);
    assign c_d      = MAX_KEY'({c_q, str});

    // Main controller: configuration capture, receive, exponentiation and transmit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            d_q        <= '0;
            mod_q      <= '0;
            c_q        <= '0;
            cr_q       <= '0;
            x_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            e_q        <= '0;
            cnt_q      <= '0;
            tx_end_q   <= 1'b0;
            msg_q      <= 1'b0;
            frame_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else if (mode && state_q != S_CFG) begin
            // Entry edge into configuration aborts everything; it does not
            // sample a stream bit, the first bit arrives on the next edge.
            state_q    <= S_CFG;
            n_q        <= '0;
            d_q        <= '0;
            mod_q      <= '0;
            cnt_q      <= '0;
            tx_end_q   <= 1'b0;
            msg_q      <= 1'b0;
            frame_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_CFG: begin
                    if (mode) begin
                        if (cnt_q < C_NW) begin
                            n_q   <= NW'({n_q, str});
                            cnt_q <= cnt_q + CW'(1);
                        end else if (w_key_ok && cnt_q < w_d_end) begin
                            d_q   <= MAX_KEY'({d_q, str});
                            cnt_q <= cnt_q + CW'(1);
                        end else if (w_key_ok && cnt_q < w_n_end) begin
                            mod_q <= MAX_KEY'({mod_q, str});
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (w_cfg_valid) begin
                        cfg_done_q <= 1'b1;
                        state_q    <= S_WAIT_START;
                    end else begin
                        cfg_err_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_WAIT_START: begin
                    if (!str) begin
                        busy_q  <= 1'b1;
                        c_q     <= '0;
                        k_q     <= w_len_m1;
                        state_q <= S_RX;
                    end
                end
                S_RX: begin
                    c_q <= c_d;
                    if (k_q == '0) begin
                        a_q     <= c_d;
                        b_q     <= MAX_KEY'(1);
                        r_q     <= '0;
                        k_q     <= w_len_m1;
                        state_q <= S_REDUCE;
                    end else begin
                        k_q <= k_q - IW'(1);
                    end
                end
                S_REDUCE: begin
                    r_q <= r_d;
                    if (k_q == '0) begin
                        cr_q    <= res_d;
                        x_q     <= x_init_d;
                        a_q     <= x_init_d;
                        b_q     <= x_init_d;
                        r_q     <= '0;
                        k_q     <= w_len_m1;
                        e_q     <= w_len_m1;
                        state_q <= S_EXP_SQ;
                    end else begin
                        k_q <= k_q - IW'(1);
                    end
                end
                S_EXP_SQ: begin
                    r_q <= r_d;
                    if (k_q == '0) begin
                        x_q     <= res_d;
                        a_q     <= res_d;
                        b_q     <= cr_q;
                        r_q     <= '0;
                        k_q     <= w_len_m1;
                        state_q <= S_EXP_MUL;
                    end else begin
                        k_q <= k_q - IW'(1);
                    end
                end
                S_EXP_MUL: begin
                    // The product is always computed; d only selects whether it is kept.
                    r_q <= r_d;
                    if (k_q == '0) begin
                        x_q <= x_mul_d;
                        r_q <= '0;
                        k_q <= w_len_m1;
                        if (e_q == '0) begin
                            tx_end_q <= 1'b0;
                            state_q  <= S_TX;
                        end else begin
                            e_q     <= e_q - IW'(1);
                            a_q     <= x_mul_d;
                            b_q     <= x_mul_d;
                            state_q <= S_EXP_SQ;
                        end
                    end else begin
                        k_q <= k_q - IW'(1);
                    end
                end
                S_TX: begin
                    if (tx_end_q) begin
                        frame_q  <= 1'b0;
                        msg_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        tx_end_q <= 1'b0;
                        state_q  <= S_WAIT_START;
                    end else begin
                        frame_q <= 1'b1;
                        msg_q   <= x_q[k_q];
                        if (k_q == '0) tx_end_q <= 1'b1;
                        else           k_q      <= k_q - IW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign msg      = msg_q;
    assign frame    = frame_q;
    assign cfg_done = cfg_done_q;
    assign cfg_err  = cfg_err_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: doc/sam_modexp_decoder.md
Name: sam_modexp_decoder

Overview:
- Parametrised successor to the SAM decryption block.
- Loads a key length code `n`, a private exponent `d` and a modulus `N` serially on `str` while `mode` is high.
- In decode mode it receives a framed ciphertext `C` serially and computes `M = C^d mod N` with constant-time square-and-multiply.
- It returns `M` serially on `msg`, qualified by `frame`.
- Key length is `L = 2^n` and is set at configuration time, up to `MAX_KEY` bits.

Parameters:
- `MAX_KEY`, default 16: maximum key length in bits. Must be a power of two, 2..1024.
- `NW`, default 4: width of the length code `n` sent first in configuration.

Ports:
- `clk`  in  1  system clock; all sampling on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  1  1 = configuration phase, 0 = decode phase.
- `str`  in  1  serial input: configuration stream, or ciphertext frame. Line idles at 1.
- `msg`  out  1  serial plaintext, MSB first.
- `frame`  out  1  high exactly while `msg` carries valid plaintext bits.
- `cfg_done`  out  1  high while a complete, valid configuration is held.
- `cfg_err`  out  1  high after the last configuration attempt was rejected.
- `busy`  out  1  high from the cycle after the ciphertext start bit until the last `msg` bit.

Behaviour:

Reset:
- All outputs are 0.
- `n`, `d`, `N` registers cleared; FSM to IDLE.
- Reset mid-operation aborts everything immediately.

States: IDLE, CFG, WAIT_START, RX, REDUCE, EXP_SQ, EXP_MUL, TX.

Configuration:
- Any state with `mode`=1 moves to CFG on the next edge.
- Any decode or transmit in progress is aborted: `msg`=0, `frame`=0, `busy`=0.
- `cfg_done` and `cfg_err` clear on entry to CFG.
- In CFG, every rising edge with `mode`=1 samples `str`, MSB first, in this order: `NW` bits of `n`, then `L` bits of `d`, then `L` bits of `N`.
- `L = 1 << n`. Bits beyond `NW + 2L` are ignored.
- On the first edge with `mode`=0, the configuration is validated. It is valid only if all three conditions hold:
  - all `NW + 2L` bits were received;
  - `L <= MAX_KEY`;
  - `N != 0`.
- Valid: `cfg_done`=1, go to WAIT_START.
- Invalid: `cfg_err`=1, `cfg_done`=0, go to IDLE. Decode stays disabled until the next valid configuration.
- Once `L > MAX_KEY` is known, further bits are discarded rather than stored.

Decode:
- WAIT_START: a sampled `str`=0 is the start bit.
- RX: the next `L` edges shift in `C`, MSB first.
- `C >= N` is legal; it is reduced first.
- `str` is ignored in IDLE, and from REDUCE through TX.

Modular multiply `R = A*B mod N`:
- Interleaved, one bit of `A` per cycle, MSB first, `L` cycles.
- Per cycle: `R = 2R`, subtract `N` if `R >= N`; then if `a_i`, `R = R + B`, subtract `N` if `R >= N`.
- Datapath is `MAX_KEY+1` bits wide. Upper bits beyond `L` are forced to 0.

Sequence:
- REDUCE: `Cr = C*1 mod N`.
- Initialise `X = 1 mod N`.
- For each bit of `d`, MSB first:
  - EXP_SQ: `X = X*X mod N`.
  - EXP_MUL: `T = X*Cr mod N`; if the `d` bit is 1 then `X = T`.
  - The multiply is always performed, for constant time.

Latency and output:
- `frame` rises on edge `L + 2L^2 + 1`, counted from the edge that sampled the last `C` bit.
- TX: `frame` stays high for exactly `L` cycles; `msg` = `X[L-1..0]`, MSB first.
- Then `frame`=0, `msg`=0, go to WAIT_START.

Boundary cases:
- `d` = 0 gives `M = 1 mod N`.
- `N` = 1 gives `M` = 0.
- `n` = 0 gives `L` = 1.
- A new start bit during REDUCE..TX is ignored; back-to-back frames are accepted from WAIT_START.

Test Plan:
1. Basic decrypt.
   - Stimulus: `MAX_KEY`=16; configure `n`=3, `d`=0x07, `N`=0x21; send start bit, then `C`=0x08.
   - Response: `cfg_done`=1; `frame` high 8 cycles starting 137 edges after the last `C` bit; `msg` = 0x02.
2. Unreduced ciphertext.
   - Stimulus: same configuration as scenario 1, `C`=0x29.
   - Response: `msg` = 0x02.
3. Oversized key and zero exponent.
   - Stimulus: configure `n`=5 (`L`=32 > 16).
   - Response: `cfg_err`=1, `cfg_done`=0; a later start bit produces no `frame`.
   - Stimulus: configure `n`=3, `d`=0x00, `N`=0x21, `C`=0x15.
   - Response: `msg` = 0x01.
4. Truncated configuration and zero modulus.
   - Stimulus: drop `mode` after 10 bits.
   - Response: `cfg_err`=1.
   - Stimulus: configure `N`=0x00.
   - Response: `cfg_err`=1; decode disabled.
5. Aborts.
   - Stimulus: raise `mode` during EXP_SQ.
   - Response: `frame`/`busy` drop next edge, `cfg_done`=0.
   - Stimulus: assert `reset` during TX.
   - Response: all outputs 0 immediately; `str` ignored until reconfigured.
6. Back-to-back frames.
   - Stimulus: configuration from scenario 1; second start bit sent the cycle after `frame` falls, `C`=0x1B (27).
   - Response: `msg` = 27^7 mod 33 = 0x03.
   - Stimulus: a start bit driven during computation.
   - Response: ignored.
